// File: rtl/writeback_buffer_pkg.sv
// Shared constants for the cache write-back buffer: FSM encoding and
// line/address width derivations.
package writeback_buffer_pkg;

  localparam int unsigned BYTE_ADDR_W = 32;
  localparam int unsigned STATE_W     = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_FWD  = 2'd1;
  localparam logic [STATE_W-1:0] ST_RD   = 2'd2;
  localparam logic [STATE_W-1:0] ST_WR   = 2'd3;

  function automatic int unsigned CLOG2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned line_bits(input int unsigned line_size);
    return 8 * line_size;
  endfunction

  function automatic int unsigned laddr_w(input int unsigned line_size);
    return BYTE_ADDR_W - CLOG2(line_size);
  endfunction

endpackage

// File: rtl/writeback_buffer_match.sv
// Youngest-match search: among valid entries whose address equals the key,
// pick the one furthest from head (most recently pushed).
module wb_match
  import writeback_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LADDR_W = 28,
  localparam int unsigned PTR_W  = CLOG2(DEPTH)
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [DEPTH*LADDR_W-1:0] i_addr,
  input  logic [PTR_W-1:0]         i_head,
  input  logic [LADDR_W-1:0]       i_key,
  output logic                     o_hit_c,
  output logic [PTR_W-1:0]         o_idx_c
);

  logic [PTR_W-1:0] w_age;
  logic [PTR_W-1:0] w_best_age;

  always_comb begin
    o_hit_c    = 1'b0;
    o_idx_c    = '0;
    w_age      = '0;
    w_best_age = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_age = PTR_W'(i) - i_head;
      if (i_valid[i] && (i_addr[i*int'(LADDR_W) +: LADDR_W] == i_key) &&
          (!o_hit_c || (w_age > w_best_age))) begin
        o_hit_c    = 1'b1;
        o_idx_c    = PTR_W'(i);
        w_best_age = w_age;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Write-back buffer between the cache and DataMemory: queues dirty victims,
// forwards fills from resident lines and lets read misses pre-empt drains.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LINE_SIZE = 16,
  localparam int unsigned LINE_BITS = line_bits(LINE_SIZE),
  localparam int unsigned LADDR_W   = laddr_w(LINE_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 evict_valid,
  output logic                 evict_ready,
  input  logic [LADDR_W-1:0]   evict_addr,
  input  logic [LINE_BITS-1:0] evict_data,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [LADDR_W-1:0]   fill_addr,
  output logic                 fill_data_valid,
  output logic [LINE_BITS-1:0] fill_data,
  output logic                 empty,
  output logic                 mem_is_input_valid,
  output logic [LADDR_W-1:0]   mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [LINE_BITS-1:0] mem_din,
  input  logic                 mem_is_output_valid,
  input  logic [LINE_BITS-1:0] mem_dout,
  input  logic                 mem_ready
);

  localparam int unsigned PTR_W = CLOG2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_nxt;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [DEPTH-1:0]     r_valid;
  logic [LADDR_W-1:0]   r_addr [DEPTH];
  logic [LINE_BITS-1:0] r_data [DEPTH];
  logic [LINE_BITS-1:0] r_fill_data;
  logic                 r_fill_data_valid;

  logic                     w_full;
  logic                     w_push;
  logic                     w_fill_acc;
  logic                     w_rd_issue;
  logic                     w_wr_issue;
  logic                     w_hit;
  logic [PTR_W-1:0]         w_hit_idx;
  logic [DEPTH*LADDR_W-1:0] w_addr_flat;

  always_comb begin
    w_addr_flat = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_addr_flat[i*int'(LADDR_W) +: LADDR_W] = r_addr[i];
    end
  end

  wb_match #(
    .DEPTH   (DEPTH),
    .LADDR_W (LADDR_W)
  ) u_match (
    .i_valid (r_valid),
    .i_addr  (w_addr_flat),
    .i_head  (r_head),
    .i_key   (fill_addr),
    .o_hit_c (w_hit),
    .o_idx_c (w_hit_idx)
  );

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_push = evict_valid && !w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Misses need a free slot behind them, so a full buffer with no hit drains first.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_acc  = 1'b0;
    w_rd_issue  = 1'b0;
    w_wr_issue  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fill_valid && (w_hit || (!w_full && mem_ready))) begin
          w_fill_acc = 1'b1;
          if (w_hit) begin
            w_state_nxt = ST_FWD;
          end else begin
            w_rd_issue  = 1'b1;
            w_state_nxt = ST_RD;
          end
        end else if ((r_count != '0) && mem_ready) begin
          w_wr_issue  = 1'b1;
          w_state_nxt = ST_WR;
        end
      end
      ST_FWD:  w_state_nxt = ST_IDLE;
      ST_RD:   if (mem_is_output_valid) w_state_nxt = ST_IDLE;
      ST_WR:   if (mem_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      w_fill_acc = 1'b0;
      w_rd_issue = 1'b0;
      w_wr_issue = 1'b0;
    end
  end

  // Push and pop never target the same slot: pop needs count>0, push needs !full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_valid           <= '0;
      r_fill_data       <= '0;
      r_fill_data_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail          <= r_tail + PTR_W'(1);
        r_valid[r_tail] <= 1'b1;
      end
      if (w_wr_issue) begin
        r_head          <= r_head + PTR_W'(1);
        r_valid[r_head] <= 1'b0;
      end
      r_count           <= r_count + CNT_W'(w_push) - CNT_W'(w_wr_issue);
      r_fill_data_valid <= 1'b0;
      if (w_fill_acc && w_hit) begin
        r_fill_data       <= r_data[w_hit_idx];
        r_fill_data_valid <= 1'b1;
      end else if ((r_state == ST_RD) && mem_is_output_valid) begin
        r_fill_data       <= mem_dout;
        r_fill_data_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= evict_addr;
      r_data[r_tail] <= evict_data;
    end
  end

  assign evict_ready        = !w_full;
  assign empty              = (r_count == '0);
  assign fill_ready         = w_fill_acc;
  assign fill_data          = r_fill_data;
  assign fill_data_valid    = r_fill_data_valid;
  assign mem_is_input_valid = w_rd_issue || w_wr_issue;
  assign mem_read           = w_rd_issue;
  assign mem_write          = w_wr_issue;
  assign mem_addr           = w_rd_issue ? fill_addr :
                              (w_wr_issue ? r_addr[r_head] : '0);
  assign mem_din            = w_wr_issue ? r_data[r_head] : '0;

endmodule
